// File: rtl/led_event_ctrl.sv
// led_event_ctrl: turns eat/crash event strobes into a timed LED trigger level
// (a single flash for an eat event, a blink burst for a crash event).
module led_event_ctrl #(
    parameter int EAT_CYC       = 10_000_000,
    parameter int BLINK_ON_CYC  = 12_500_000,
    parameter int BLINK_OFF_CYC = 12_500_000,
    parameter int CRASH_BLINKS  = 3
) (
    input  logic sys_clk,
    input  logic sys_rst_n,
    input  logic eat_in,
    input  logic crash_in,
    input  logic abort,
    output logic trigger,
    output logic busy,
    output logic crash_active
);
    localparam int MAX_A = (EAT_CYC > BLINK_ON_CYC) ? EAT_CYC : BLINK_ON_CYC;
    localparam int MAX_C = (MAX_A > BLINK_OFF_CYC) ? MAX_A : BLINK_OFF_CYC;
    localparam int CW    = (MAX_C > 1) ? $clog2(MAX_C) : 1;
    localparam logic [CW-1:0] EAT_LAST = CW'(EAT_CYC - 1);
    localparam logic [CW-1:0] ON_LAST  = CW'(BLINK_ON_CYC - 1);
    localparam logic [CW-1:0] OFF_LAST = CW'(BLINK_OFF_CYC - 1);
    localparam logic [3:0]    IDX_LAST = 4'(CRASH_BLINKS - 1);

    typedef enum logic [1:0] {IDLE, EAT_ON, BLINK_ON, BLINK_OFF} state_t;

    state_t state, state_nx;
    logic [CW-1:0] cnt, cnt_nx;
    logic [3:0] idx, idx_nx;
    logic eat_d, crash_d;
    logic eat_evt, crash_evt;

    assign eat_evt   = eat_in & ~eat_d;
    assign crash_evt = crash_in & ~crash_d;

    // History flops reset high so a level already asserted at reset release is not an event.
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state        <= IDLE;
            cnt          <= '0;
            idx          <= '0;
            eat_d        <= 1'b1;
            crash_d      <= 1'b1;
            trigger      <= 1'b0;
            busy         <= 1'b0;
            crash_active <= 1'b0;
        end else begin
            state        <= state_nx;
            cnt          <= cnt_nx;
            idx          <= idx_nx;
            eat_d        <= eat_in;
            crash_d      <= crash_in;
            trigger      <= (state_nx == EAT_ON) || (state_nx == BLINK_ON);
            busy         <= state_nx != IDLE;
            crash_active <= (state_nx == BLINK_ON) || (state_nx == BLINK_OFF);
        end
    end

    always_comb begin
        state_nx = state;
        cnt_nx   = cnt;
        idx_nx   = idx;
        if (abort) begin
            state_nx = IDLE;
            cnt_nx   = '0;
            idx_nx   = '0;
        end else begin
            case (state)
                IDLE, EAT_ON: begin
                    if (crash_evt) begin
                        state_nx = BLINK_ON;
                        cnt_nx   = '0;
                        idx_nx   = '0;
                    end else if (eat_evt) begin
                        state_nx = EAT_ON;
                        cnt_nx   = '0;
                    end else if (state == EAT_ON) begin
                        state_nx = (cnt == EAT_LAST) ? IDLE : EAT_ON;
                        cnt_nx   = (cnt == EAT_LAST) ? '0 : cnt + 1'b1;
                    end
                end
                BLINK_ON: begin
                    if (cnt == ON_LAST) begin
                        state_nx = (idx == IDX_LAST) ? IDLE : BLINK_OFF;
                        idx_nx   = (idx == IDX_LAST) ? '0 : idx + 4'd1;
                        cnt_nx   = '0;
                    end else begin
                        cnt_nx = cnt + 1'b1;
                    end
                end
                BLINK_OFF: begin
                    state_nx = (cnt == OFF_LAST) ? BLINK_ON : BLINK_OFF;
                    cnt_nx   = (cnt == OFF_LAST) ? '0 : cnt + 1'b1;
                end
                default: begin
                    state_nx = IDLE;
                    cnt_nx   = '0;
                    idx_nx   = '0;
                end
            endcase
        end
    end
endmodule
